// File: rtl/rom_bus_arbiter_pkg.sv
// Shared constants for the ROM bus arbiter: strobe levels, reset level,
// default bus widths and the arbiter state encoding.
package rom_bus_arbiter_pkg;

    // Active-low strobe levels used on the master and ROM interfaces
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Plain logic levels for active-high signals
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Level of the asynchronous reset input that clears the block
    localparam logic RESET_ENABLE = 1'b1;

    // Default ROM word-address and word-data widths
    localparam int ROM_ADDR_W = 11;
    localparam int ROM_DATA_W = 32;

    // Arbiter state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/rom_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: starting just after the previous owner
// and wrapping around, returns the first active requester.
module rom_arb_rr_pick
    import rom_bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 4,
    localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [OW-1:0]        last_owner,
    output logic                 valid,
    output logic [OW-1:0]        winner
);

    // Scan last_owner+1, last_owner+2, ... (mod N_MASTERS); the first hit wins
    always_comb begin
        logic [OW-1:0] idx_w;
        idx_w  = '0;
        valid  = LOW;
        winner = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx_w = OW'((int'(last_owner) + k) % N_MASTERS);
            if (!valid && req[idx_w] == HIGH) begin
                valid  = HIGH;
                winner = idx_w;
            end
        end
    end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Shares one single-port ROM between up to four bus masters. Requests are
// served round-robin, one transfer per grant; a watchdog turns a silent ROM
// into an error response so the bus can never hang.
module rom_bus_arbiter
    import rom_bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int DATA_W    = ROM_DATA_W,
    parameter int TIMEOUT   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_MASTERS-1:0]        m_req_n,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    output logic [N_MASTERS-1:0]        m_grnt_n,
    output logic [N_MASTERS-1:0]        m_rdy_n,
    output logic [N_MASTERS-1:0]        m_err,
    output logic [DATA_W-1:0]           m_rd_data,
    output logic                        rom_cs_n,
    output logic                        rom_as_n,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [DATA_W-1:0]           rom_rd_data,
    input  logic                        rom_rdy_n
);

    localparam int OW = $clog2(N_MASTERS);
    localparam int CW = $clog2(TIMEOUT);
    // Last ACCESS cycle before the watchdog gives up on the ROM
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]           state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        last_owner_q, last_owner_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N_MASTERS-1:0] grnt_n_q, grnt_n_d;
    logic [N_MASTERS-1:0] rdy_n_q, rdy_n_d;
    logic [N_MASTERS-1:0] err_q, err_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 cs_n_q, cs_n_d;
    logic                 as_n_q, as_n_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;

    logic [N_MASTERS-1:0] req;
    logic                 pick_valid;
    logic [OW-1:0]        pick_winner;
    logic [ADDR_W-1:0]    pick_addr;
    logic [N_MASTERS-1:0] pick_onehot;
    logic [N_MASTERS-1:0] owner_onehot;

    assign req = ~m_req_n;

    rom_arb_rr_pick #(
        .N_MASTERS (N_MASTERS)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // One-hot forms of the candidate and current owner, and the candidate's address
    always_comb begin
        pick_onehot  = '0;
        owner_onehot = '0;
        pick_addr    = '0;
        pick_onehot[pick_winner] = HIGH;
        owner_onehot[owner_q]    = HIGH;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (pick_winner == OW'(i)) begin
                pick_addr = m_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Arbiter FSM: IDLE grants, ACCESS strobes the ROM and waits, RESP answers the owner
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        grnt_n_d     = grnt_n_q;
        rdy_n_d      = rdy_n_q;
        err_d        = err_q;
        rd_data_d    = rd_data_q;
        cs_n_d       = cs_n_q;
        as_n_d       = as_n_q;
        addr_d       = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d  = ST_ACCESS;
                    owner_d  = pick_winner;
                    grnt_n_d = ~pick_onehot;
                    addr_d   = pick_addr;
                    cs_n_d   = ENABLE_;
                    as_n_d   = ENABLE_;
                    cnt_d    = '0;
                end
            end
            ST_ACCESS: begin
                as_n_d = DISABLE_;
                if (rom_rdy_n == ENABLE_) begin
                    state_d   = ST_RESP;
                    rd_data_d = rom_rd_data;
                    rdy_n_d   = ~owner_onehot;
                    cs_n_d    = DISABLE_;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    rd_data_d = '0;
                    rdy_n_d   = ~owner_onehot;
                    err_d     = owner_onehot;
                    cs_n_d    = DISABLE_;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                grnt_n_d     = {N_MASTERS{DISABLE_}};
                rdy_n_d      = {N_MASTERS{DISABLE_}};
                err_d        = '0;
                last_owner_d = owner_q;
                cnt_d        = '0;
            end
            default: begin
                state_d  = ST_IDLE;
                grnt_n_d = {N_MASTERS{DISABLE_}};
                rdy_n_d  = {N_MASTERS{DISABLE_}};
                err_d    = '0;
                cs_n_d   = DISABLE_;
                as_n_d   = DISABLE_;
                cnt_d    = '0;
            end
        endcase
    end

    // State and output registers; reset clears them immediately, aborting any transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset == RESET_ENABLE) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(N_MASTERS - 1);
            cnt_q        <= '0;
            grnt_n_q     <= {N_MASTERS{DISABLE_}};
            rdy_n_q      <= {N_MASTERS{DISABLE_}};
            err_q        <= '0;
            rd_data_q    <= '0;
            cs_n_q       <= DISABLE_;
            as_n_q       <= DISABLE_;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            grnt_n_q     <= grnt_n_d;
            rdy_n_q      <= rdy_n_d;
            err_q        <= err_d;
            rd_data_q    <= rd_data_d;
            cs_n_q       <= cs_n_d;
            as_n_q       <= as_n_d;
            addr_q       <= addr_d;
        end
    end

    assign m_grnt_n  = grnt_n_q;
    assign m_rdy_n   = rdy_n_q;
    assign m_err     = err_q;
    assign m_rd_data = rd_data_q;
    assign rom_cs_n  = cs_n_q;
    assign rom_as_n  = as_n_q;
    assign rom_addr  = addr_q;

endmodule
